// File: rtl/control_pkg.sv
// ============================================================================
//  control_pkg
//  Shared encodings for the multicycle ARM-subset control unit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package control_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    // Immediate extender selects
    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    // ALU operand selects
    localparam logic [1:0] SRCA_REG  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Instruction classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing commands
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

`default_nettype wire

// File: rtl/cond_logic.sv
// ============================================================================
//  cond_logic
//  NZCV flag register, condition evaluation, per-instruction condition latch
//  and gating of every architectural write enable.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module cond_logic
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       latch_cond,      // high in DECODE
    input  logic       flag_update_req, // execute state of a flag-setting op
    input  logic       rd_is_pc,
    input  logic       pc_fetch,
    input  logic       branch,
    input  logic       reg_write_req,
    input  logic       mem_write_req,
    input  logic       ir_write_req,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       ir_write
);

    logic [3:0] flags;      // {N, Z, C, V}
    logic       cond_ex;
    logic       cond_ex_q;
    logic       pcs;

    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags;

    // Evaluate the condition field against the current flag register
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_f;
            COND_NE: cond_ex = ~z_f;
            COND_CS: cond_ex = c_f;
            COND_CC: cond_ex = ~c_f;
            COND_MI: cond_ex = n_f;
            COND_PL: cond_ex = ~n_f;
            COND_VS: cond_ex = v_f;
            COND_VC: cond_ex = ~v_f;
            COND_HI: cond_ex = c_f & ~z_f;
            COND_LS: cond_ex = ~c_f | z_f;
            COND_GE: cond_ex = (n_f == v_f);
            COND_LT: cond_ex = (n_f != v_f);
            COND_GT: cond_ex = ~z_f & (n_f == v_f);
            COND_LE: cond_ex = z_f | (n_f != v_f);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Freeze the condition outcome in DECODE so later flag writes cannot
    // change the fate of the instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags     <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            if (latch_cond)
                cond_ex_q <= cond_ex;
            if (flag_update_req && cond_ex_q)
                flags <= alu_flags;
        end
    end

    // PC-relative writes: branches and any register writeback to R15
    assign pcs = branch | (reg_write_req & rd_is_pc);

    // Reset suppresses all enables, even though FETCH would request some
    assign pc_write  = rst_n & (pc_fetch | (pcs & cond_ex_q));
    assign reg_write = rst_n & reg_write_req & cond_ex_q;
    assign mem_write = rst_n & mem_write_req & cond_ex_q;
    assign ir_write  = rst_n & ir_write_req;

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
//  multicycle_controller
//  Sequencer for the multicycle ARM-subset core: Moore FSM driving datapath
//  selects, with condition/flag handling delegated to cond_logic.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl
);

    state_t     state, next_state;

    logic       ir_write_req, pc_fetch, reg_write_req, mem_write_req, branch;
    logic       latch_cond, flag_update_req;
    logic [1:0] dp_alu;
    logic       dp_no_write, dp_flag_w;

    // Data-processing command decode: ALU op, suppressed writeback, flag write
    always_comb begin
        dp_alu      = ALU_ADD;
        dp_no_write = 1'b1;
        dp_flag_w   = 1'b0;
        case (Funct[4:1])
            CMD_ADD: begin dp_alu = ALU_ADD; dp_no_write = 1'b0; dp_flag_w = Funct[0]; end
            CMD_SUB: begin dp_alu = ALU_SUB; dp_no_write = 1'b0; dp_flag_w = Funct[0]; end
            CMD_AND: begin dp_alu = ALU_AND; dp_no_write = 1'b0; dp_flag_w = Funct[0]; end
            CMD_ORR: begin dp_alu = ALU_ORR; dp_no_write = 1'b0; dp_flag_w = Funct[0]; end
            CMD_CMP: begin dp_alu = ALU_SUB; dp_no_write = 1'b1; dp_flag_w = 1'b1;     end
            default: ;
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Next-state and Moore output decode
    always_comb begin
        next_state      = state;
        ir_write_req    = 1'b0;
        pc_fetch        = 1'b0;
        reg_write_req   = 1'b0;
        mem_write_req   = 1'b0;
        branch          = 1'b0;
        latch_cond      = 1'b0;
        flag_update_req = 1'b0;
        AdrSrc          = 1'b0;
        ALUSrcA         = SRCA_REG;
        ALUSrcB         = SRCB_REG;
        ResultSrc       = RES_ALUOUT;
        ImmSrc          = IMM_8;
        ALUControl      = ALU_ADD;
        case (state)
            S_FETCH: begin
                ir_write_req = 1'b1;
                pc_fetch     = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALU;
                next_state   = S_DECODE;
            end
            S_DECODE: begin
                latch_cond = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALU;
                case (Op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_12;
                ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
                next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_req = 1'b1;
                next_state    = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc        = 1'b1;
                mem_write_req = 1'b1;
                next_state    = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB         = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_REG;
                ALUControl      = dp_alu;
                flag_update_req = dp_flag_w;
                next_state      = dp_no_write ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_req = 1'b1;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_24;
                ResultSrc  = RES_ALU;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    cond_logic u_cond (
        .clk             (clk),
        .rst_n           (rst_n),
        .cond            (Cond),
        .alu_flags       (ALUFlags),
        .latch_cond      (latch_cond),
        .flag_update_req (flag_update_req),
        .rd_is_pc        (Rd == 4'd15),
        .pc_fetch        (pc_fetch),
        .branch          (branch),
        .reg_write_req   (reg_write_req),
        .mem_write_req   (mem_write_req),
        .ir_write_req    (ir_write_req),
        .pc_write        (PCWrite),
        .reg_write       (RegWrite),
        .mem_write       (MemWrite),
        .ir_write        (IRWrite)
    );

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the multicycle ARM-subset core. It decodes the latched instruction fields and steps a state machine through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath select lines, including `ImmSrc` to the immediate extender. It also holds the NZCV flag register and evaluates condition codes, so it gates every architectural write.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `Cond`  in  4  instruction [31:28]
- `Op`  in  2  instruction [27:26]
- `Funct`  in  6  instruction [25:20]; [5]=I, [4:1]=cmd, [0]=S (DP) / L (mem); [3]=U (mem)
- `Rd`  in  4  instruction [15:12]
- `ALUFlags`  in  4  NZCV from ALU, valid in execute states
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite`  out  1 each  write enables
- `AdrSrc`  out  1  0=PC, 1=ALUOut to memory address
- `ALUSrcA`  out  2  00=Reg A, 01=PC
- `ALUSrcB`  out  2  00=Reg B, 01=ExtImm, 10=const 4
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALU result
- `ImmSrc`  out  2  00=imm8 zero-ext, 01=imm12 zero-ext, 10=imm24 sign-ext ×4
- `ALUControl`  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (Op=01), EXECUTER (Op=00, I=0), EXECUTEI (Op=00, I=1), BRANCH (Op=10), FETCH (Op=11, undefined; no writes).
  - MEMADR→MEMRD (L=1) or MEMWR (L=0).
  - MEMRD→MEMWB.
  - EXECUTER/EXECUTEI→ALUWB, or →FETCH when NoWrite.
  - MEMWB, MEMWR, ALUWB and BRANCH→FETCH.
- FETCH outputs: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1.
- DECODE outputs: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10.
- MEMADR outputs: ALUSrcA=00, ALUSrcB=01, ImmSrc=01, ADD if U=1 else SUB.
- MEMRD outputs: AdrSrc=1.
- MEMWB outputs: ResultSrc=01, RegWrite.
- MEMWR outputs: AdrSrc=1, MemWrite.
- Execute states: EXECUTER uses ALUSrcB=00; EXECUTEI uses ALUSrcB=01 with ImmSrc=00.
- ALUWB outputs: ResultSrc=00, RegWrite.
- BRANCH outputs: ALUSrcA=00, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, branch.
- DP cmd decode:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1010 CMP: SUB, NoWrite, flags always written.
  - Any other cmd: ADD, NoWrite, no flag write.
- Conditions: EQ Z, NE ¬Z, CS C, CC ¬C, MI N, PL ¬N, VS V, VC ¬V, HI C∧¬Z, LS ¬C∨Z, GE N=V, LT N≠V, GT ¬Z∧N=V, LE Z∨N≠V, AL 1, 1111 → 0.
- CondEx is computed from `Cond` and the flag register in DECODE and latched into `cond_ex_q` at the end of DECODE. Later flag updates therefore do not affect the current instruction.
- Flags register update: in EXECUTER/EXECUTEI, NZCV ← `ALUFlags` when (S=1 or CMP) and `cond_ex_q`=1.
- PC-relative write (PCS) = branch state, or RegWrite-state with Rd=15.
- Write-enable gating:
  - `PCWrite` = FETCH | (PCS ∧ `cond_ex_q`).
  - `RegWrite` and `MemWrite` are gated by `cond_ex_q`.
  - `IRWrite` is never gated.
  - Failed-condition instructions still walk their full state path.
- ImmSrc value in states that do not use ExtImm: 00.

## Timing
- While `rst_n`=0:
  - state=FETCH, flags=0000, `cond_ex_q`=0.
  - All four write enables forced 0; selects take their FETCH values.
- First fetch occurs on the first rising edge after `rst_n` deasserts.
- Instruction latency in cycles:
  - DP with writeback: 4.
  - CMP or NoWrite: 3.
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - Undefined: 2.
- All outputs are Moore-decoded from state plus latched fields; no output depends combinationally on `ALUFlags`.
- Reset mid-instruction aborts it immediately. The partial instruction leaves no further register, memory or PC writes.

## Structure
- Package `control_pkg`:
  - state enum;
  - ImmSrc, ALUSrcA/B, ResultSrc and ALUControl encodings;
  - DP cmd constants;
  - condition-code constants.
- Sub-module `cond_logic`: flag register, condition evaluation and `cond_ex_q` latch, plus write-enable gating.

## Test plan
- Reset: hold `rst_n`=0 over 3 edges → write enables 0, state FETCH. Release → IRWrite=1 and PCWrite=1 on the next cycle.
- ADD imm, S=1, Cond=1110, ALUFlags=0100:
  - visits FETCH, DECODE, EXECUTEI, ALUWB;
  - ImmSrc=00 in EXECUTEI;
  - RegWrite in cycle 4;
  - flags become 0100.
- CMP sets Z; then BEQ (Cond=0000, Op=10) → BRANCH with ImmSrc=10 and PCWrite=1. BNE instead → PCWrite=0 in BRANCH, 3 cycles total.
- LDR U=0 → ALUControl=01 and ImmSrc=01 in MEMADR, RegWrite in MEMWB, 5 cycles. STR with failed Cond → MemWrite stays 0 for all 4 cycles.
- ALU writeback with Rd=15, Cond=AL → PCWrite=1 and RegWrite=1 in ALUWB. Op=11 → DECODE returns to FETCH with no writes.
- Assert `rst_n` in MEMRD → state FETCH asynchronously, no MEMWB RegWrite occurs, flags cleared.
